// File: rtl/sha_ctrl_pkg.sv
// Shared widths and output-FSM encoding for the dual SHA controller.
package sha_ctrl_pkg;
    localparam int BW_SRAM_ADDR     = 8;
    localparam int BW_SRAM_DATA     = 64;
    localparam int BW_DIGEST        = 256;
    localparam int WORDS_PER_DIGEST = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND2 = 2'd1,
        ST_SEND3 = 2'd2
    } out_state_e;
endpackage

// File: rtl/sha_dual_ctrl_if.sv
// Message-SRAM read port shared by the two engines; master = engines/SRAM, slave = controller.
interface sha_dual_ctrl_if
    import sha_ctrl_pkg::*;
#(
    parameter int AW = BW_SRAM_ADDR,
    parameter int DW = BW_SRAM_DATA
);
    logic          sha2_req;
    logic [AW-1:0] sha2_addr;
    logic          sha2_gnt;
    logic          sha2_rvalid;
    logic          sha3_req;
    logic [AW-1:0] sha3_addr;
    logic          sha3_gnt;
    logic          sha3_rvalid;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_data;

    modport master (
        output sha2_req, sha2_addr, sha3_req, sha3_addr, sram_data,
        input  sha2_gnt, sha2_rvalid, sha3_gnt, sha3_rvalid, sram_addr
    );

    modport slave (
        input  sha2_req, sha2_addr, sha3_req, sha3_addr, sram_data,
        output sha2_gnt, sha2_rvalid, sha3_gnt, sha3_rvalid, sram_addr
    );
endinterface

// File: rtl/sha_rr_arb2.sv
// Two-requester round-robin arbiter; ptr_reg names the requester preferred on contention.
module sha_rr_arb2 (
    input  logic       clk,
    input  logic       srst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic ptr_reg;
    logic ptr_next;

    always_comb begin
        gnt      = 2'b00;
        ptr_next = ptr_reg;
        if (req == 2'b11) begin
            gnt[ptr_reg] = 1'b1;
            ptr_next     = ~ptr_reg;
        end else begin
            gnt = req;
        end
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            ptr_reg <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end
endmodule

// File: rtl/sha_dual_ctrl.sv
// Launches SHA-256/SHA3-256 together, shares the SRAM read port, and serialises both digests.
module sha_dual_ctrl #(
    parameter int BW_SRAM_ADDR = sha_ctrl_pkg::BW_SRAM_ADDR,
    parameter int BW_SRAM_DATA = sha_ctrl_pkg::BW_SRAM_DATA,
    parameter int BW_DIGEST    = sha_ctrl_pkg::BW_DIGEST
) (
    input  logic                    clk,
    input  logic                    srst_n,
    input  logic                    enable,
    sha_dual_ctrl_if.slave          bus,
    output logic                    sha2_start,
    output logic                    sha3_start,
    input  logic                    sha2_done,
    input  logic                    sha3_done,
    input  logic [BW_DIGEST-1:0]    sha2_digest,
    input  logic [BW_DIGEST-1:0]    sha3_digest,
    output logic                    SHA2_valid,
    output logic                    SHA3_valid,
    output logic [BW_SRAM_DATA-1:0] data_out,
    output logic                    busy,
    output logic                    err
);
    import sha_ctrl_pkg::*;

    localparam logic [1:0] CNT_LAST = 2'(WORDS_PER_DIGEST - 1);

    logic [1:0]              req;
    logic [1:0]              gnt;
    logic [BW_SRAM_ADDR-1:0] addr_sel;
    logic                    rvalid2_reg;
    logic                    rvalid3_reg;

    assign req = {bus.sha3_req, bus.sha2_req};

    sha_rr_arb2 u_arb (
        .clk    (clk),
        .srst_n (srst_n),
        .req    (req),
        .gnt    (gnt)
    );

    always_comb begin
        addr_sel = '0;
        if (gnt[0]) begin
            addr_sel = bus.sha2_addr;
        end else if (gnt[1]) begin
            addr_sel = bus.sha3_addr;
        end
    end

    assign bus.sram_addr   = addr_sel;
    assign bus.sha2_gnt    = gnt[0];
    assign bus.sha3_gnt    = gnt[1];
    assign bus.sha2_rvalid = rvalid2_reg;
    assign bus.sha3_rvalid = rvalid3_reg;

    // SRAM has one cycle of read latency, so the grant is delayed by one cycle to tag the data.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            rvalid2_reg <= 1'b0;
            rvalid3_reg <= 1'b0;
        end else begin
            rvalid2_reg <= gnt[0];
            rvalid3_reg <= gnt[1];
        end
    end

    // Index 0 = SHA-256, index 1 = SHA3-256 throughout.
    logic [1:0]              done_vec;
    logic [1:0]              pend_vec;
    logic [1:0]              pend_clr;
    logic [BW_DIGEST-1:0]    dig_in   [2];
    logic [BW_SRAM_DATA-1:0] word_arr [2][WORDS_PER_DIGEST];

    assign done_vec  = {sha3_done, sha2_done};
    assign dig_in[0] = sha2_digest;
    assign dig_in[1] = sha3_digest;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_eng
            logic                 pend_reg;
            logic [BW_DIGEST-1:0] dig_reg;

            always_ff @(posedge clk or negedge srst_n) begin
                if (!srst_n) begin
                    pend_reg <= 1'b0;
                    dig_reg  <= '0;
                end else if (done_vec[gi]) begin
                    pend_reg <= 1'b1;
                    dig_reg  <= dig_in[gi];
                end else if (pend_clr[gi]) begin
                    pend_reg <= 1'b0;
                end
            end

            assign pend_vec[gi] = pend_reg;

            for (genvar gw = 0; gw < WORDS_PER_DIGEST; gw++) begin : g_word
                assign word_arr[gi][gw] = dig_reg[BW_DIGEST-1-gw*BW_SRAM_DATA -: BW_SRAM_DATA];
            end
        end
    endgenerate

    out_state_e              state_reg;
    out_state_e              state_next;
    logic [1:0]              cnt_reg;
    logic [1:0]              cnt_next;
    logic                    own;
    logic                    finish;
    logic [BW_SRAM_DATA-1:0] data_reg;
    logic [BW_SRAM_DATA-1:0] data_next;
    logic                    v2_reg;
    logic                    v2_next;
    logic                    v3_reg;
    logic                    v3_next;

    assign own = (state_reg == ST_SEND3);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pend_clr   = 2'b00;
        finish     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (pend_vec[0]) begin
                    state_next = ST_SEND2;
                end else if (pend_vec[1]) begin
                    state_next = ST_SEND3;
                end
            end
            ST_SEND2, ST_SEND3: begin
                if (cnt_reg != CNT_LAST) begin
                    cnt_next = cnt_reg + 2'd1;
                end else begin
                    finish        = 1'b1;
                    cnt_next      = '0;
                    pend_clr[own] = 1'b1;
                    if (pend_vec[~own]) begin
                        state_next = own ? ST_SEND2 : ST_SEND3;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so word 0 appears in the same cycle the FSM leaves IDLE.
    always_comb begin
        data_next = '0;
        v2_next   = 1'b0;
        v3_next   = 1'b0;
        case (state_next)
            ST_SEND2: begin
                data_next = word_arr[0][cnt_next];
                v2_next   = (cnt_next == 2'd0);
            end
            ST_SEND3: begin
                data_next = word_arr[1][cnt_next];
                v3_next   = (cnt_next == 2'd0);
            end
            default: ;
        endcase
    end

    logic start_reg;
    logic busy_reg;
    logic sent_one_reg;
    logic err_reg;

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            data_reg     <= '0;
            v2_reg       <= 1'b0;
            v3_reg       <= 1'b0;
            start_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            sent_one_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
            v2_reg    <= v2_next;
            v3_reg    <= v3_next;
            start_reg <= enable && !busy_reg;
            err_reg   <= err_reg | (|(done_vec & pend_vec));
            // busy drops once the second digest of the message has left the serialiser.
            if (enable && !busy_reg) begin
                busy_reg     <= 1'b1;
                sent_one_reg <= 1'b0;
            end else if (busy_reg && finish) begin
                if (sent_one_reg) begin
                    busy_reg <= 1'b0;
                end
                sent_one_reg <= ~sent_one_reg;
            end
        end
    end

    assign sha2_start = start_reg;
    assign sha3_start = start_reg;
    assign SHA2_valid = v2_reg;
    assign SHA3_valid = v3_reg;
    assign data_out   = data_reg;
    assign busy       = busy_reg;
    assign err        = err_reg;
endmodule

// File: tb/tb_sha_dual_ctrl.sv
// Directed + randomized bench for sha_dual_ctrl with a behavioural SRAM and output schedule model.
module tb_sha_dual_ctrl;
    import sha_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         srst_n = 1'b1;
    logic         enable = 1'b0;
    logic         sha2_start, sha3_start;
    logic         sha2_done = 1'b0, sha3_done = 1'b0;
    logic [255:0] sha2_digest = '0, sha3_digest = '0;
    logic         SHA2_valid, SHA3_valid;
    logic [63:0]  data_out;
    logic         busy, err;

    int tests = 0;
    int fails = 0;

    sha_dual_ctrl_if bus ();

    sha_dual_ctrl dut (
        .clk         (clk),
        .srst_n      (srst_n),
        .enable      (enable),
        .bus         (bus),
        .sha2_start  (sha2_start),
        .sha3_start  (sha3_start),
        .sha2_done   (sha2_done),
        .sha3_done   (sha3_done),
        .sha2_digest (sha2_digest),
        .sha3_digest (sha3_digest),
        .SHA2_valid  (SHA2_valid),
        .SHA3_valid  (SHA3_valid),
        .data_out    (data_out),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: one-cycle registered read.
    logic [63:0] mem [256];
    always @(posedge clk) bus.sram_data <= mem[bus.sram_addr];

    // Expected output timeline, indexed by bench cycle within a scenario.
    logic         sched2 [16];
    logic         sched3 [16];
    logic [255:0] sdig2  [16];
    logic [255:0] sdig3  [16];
    logic [63:0]  exp_d  [16];
    logic         exp_v2 [16];
    logic         exp_v3 [16];
    int           exp_busy [16];

    task automatic chk1(input string tag, input logic obs, input logic expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [255:0] rand_dig();
        logic [255:0] r = '0;
        for (int k = 0; k < 8; k++) r = {r[223:0], 32'($urandom())};
        return r;
    endfunction

    task automatic clear_sched();
        for (int c = 0; c < 16; c++) begin
            sched2[c] = 1'b0; sched3[c] = 1'b0;
            sdig2[c] = '0;    sdig3[c] = '0;
            exp_d[c] = '0;    exp_v2[c] = 1'b0; exp_v3[c] = 1'b0;
            exp_busy[c] = -1;
        end
    endtask

    // A digest is emitted as four 64-bit slices, most significant first, marker on the first.
    task automatic put_digest(input int start, input int which, input logic [255:0] dig);
        for (int k = 0; k < 4; k++) begin
            exp_d[start+k]  = 64'(dig >> (64 * (3 - k)));
            exp_v2[start+k] = (which == 0) && (k == 0);
            exp_v3[start+k] = (which == 1) && (k == 0);
        end
    endtask

    task automatic run_sched(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            chk64($sformatf("data_out c%0d", c), data_out, exp_d[c]);
            chk1($sformatf("SHA2_valid c%0d", c), SHA2_valid, exp_v2[c]);
            chk1($sformatf("SHA3_valid c%0d", c), SHA3_valid, exp_v3[c]);
            if (exp_busy[c] >= 0) chk1($sformatf("busy c%0d", c), busy, exp_busy[c] != 0);
            sha2_done   = sched2[c];
            sha2_digest = sdig2[c];
            sha3_done   = sched3[c];
            sha3_digest = sdig3[c];
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk64({tag, " data_out"}, data_out, 64'd0);
        chk1({tag, " SHA2_valid"}, SHA2_valid, 1'b0);
        chk1({tag, " SHA3_valid"}, SHA3_valid, 1'b0);
        chk1({tag, " busy"}, busy, 1'b0);
        chk1({tag, " err"}, err, 1'b0);
        chk1({tag, " sha2_start"}, sha2_start, 1'b0);
        chk1({tag, " sha3_start"}, sha3_start, 1'b0);
        chk1({tag, " sha2_rvalid"}, bus.sha2_rvalid, 1'b0);
        chk1({tag, " sha3_rvalid"}, bus.sha3_rvalid, 1'b0);
        chk1({tag, " sha2_gnt"}, bus.sha2_gnt, 1'b0);
        chk1({tag, " sha3_gnt"}, bus.sha3_gnt, 1'b0);
        chk64({tag, " sram_addr"}, 64'(bus.sram_addr), 64'd0);
    endtask

    initial begin
        logic         pref;
        logic         r2, r3;
        logic [7:0]   a2, a3, exp_addr;
        logic         pr_rv2, pr_rv3;
        logic [7:0]   pr_addr;
        int           winner;
        logic [255:0] d2, d3, e1, e2;

        bus.sha2_req = 1'b0; bus.sha2_addr = '0;
        bus.sha3_req = 1'b0; bus.sha3_addr = '0;
        for (int i = 0; i < 256; i++) mem[i] = {32'($urandom()), 32'($urandom())};

        // Reset state
        #2 srst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        srst_n = 1'b1;

        // Start pulses and ignored second enable
        @(posedge clk); #1;
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        chk1("sha2_start pulse", sha2_start, 1'b1);
        chk1("sha3_start pulse", sha3_start, 1'b1);
        chk1("busy set", busy, 1'b1);
        @(posedge clk); #1;
        chk1("sha2_start end", sha2_start, 1'b0);
        chk1("sha3_start end", sha3_start, 1'b0);
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        chk1("enable busy sha2_start", sha2_start, 1'b0);
        chk1("enable busy sha3_start", sha3_start, 1'b0);
        chk1("busy held", busy, 1'b1);

        // Arbitration: 6 cycles of contention, then random requests
        pref = 1'b0;
        pr_rv2 = 1'b0; pr_rv3 = 1'b0; pr_addr = '0;
        for (int i = 0; i < 31; i++) begin
            @(posedge clk); #1;
            if (i > 0) begin
                chk1($sformatf("sha2_rvalid i%0d", i), bus.sha2_rvalid, pr_rv2);
                chk1($sformatf("sha3_rvalid i%0d", i), bus.sha3_rvalid, pr_rv3);
                if (pr_rv2 || pr_rv3)
                    chk64($sformatf("sram_data i%0d", i), bus.sram_data, mem[pr_addr]);
            end
            if (i < 30) begin
                r2 = (i < 6) ? 1'b1 : 1'($urandom_range(0, 1));
                r3 = (i < 6) ? 1'b1 : 1'($urandom_range(0, 1));
                a2 = 8'($urandom_range(0, 127));
                a3 = 8'($urandom_range(128, 255));
                bus.sha2_req = r2; bus.sha2_addr = a2;
                bus.sha3_req = r3; bus.sha3_addr = a3;
                #1;
                if (r2 && r3) begin
                    winner = pref ? 1 : 0;
                    pref   = ~pref;
                end else if (r2) winner = 0;
                else if (r3)     winner = 1;
                else             winner = -1;
                exp_addr = (winner == 0) ? a2 : (winner == 1) ? a3 : 8'd0;
                chk1($sformatf("sha2_gnt i%0d", i), bus.sha2_gnt, winner == 0);
                chk1($sformatf("sha3_gnt i%0d", i), bus.sha3_gnt, winner == 1);
                chk64($sformatf("sram_addr i%0d", i), 64'(bus.sram_addr), 64'(exp_addr));
                pr_rv2 = (winner == 0); pr_rv3 = (winner == 1); pr_addr = exp_addr;
            end
        end
        bus.sha2_req = 1'b0; bus.sha3_req = 1'b0;

        // Both digests in the same cycle: SHA2 then SHA3 back-to-back, busy drops after
        clear_sched();
        d2 = rand_dig(); d3 = rand_dig();
        sched2[0] = 1'b1; sdig2[0] = d2;
        sched3[0] = 1'b1; sdig3[0] = d3;
        put_digest(2, 0, d2);
        put_digest(6, 1, d3);
        for (int c = 1; c < 10; c++) exp_busy[c] = 1;
        exp_busy[10] = 0; exp_busy[11] = 0;
        run_sched(12);

        // Single SHA2 digest with a known pattern
        clear_sched();
        d2 = 256'h0123456789abcdef_fedcba9876543210_0011223344556677_8899aabbccddeeff;
        sched2[0] = 1'b1; sdig2[0] = d2;
        put_digest(2, 0, d2);
        for (int c = 0; c < 7; c++) exp_busy[c] = 0;
        run_sched(7);
        chk1("err clean", err, 1'b0);

        // Overrun: second SHA3 done while the first is still pending
        clear_sched();
        d2 = rand_dig(); e1 = rand_dig(); e2 = rand_dig();
        sched2[0] = 1'b1; sdig2[0] = d2;
        sched3[1] = 1'b1; sdig3[1] = e1;
        sched3[2] = 1'b1; sdig3[2] = e2;
        put_digest(2, 0, d2);
        put_digest(6, 1, e2);
        run_sched(11);
        chk1("err overrun", err, 1'b1);

        // Reset while word 2 of SEND2 is on the bus
        clear_sched();
        d2 = rand_dig();
        sched2[0] = 1'b1; sdig2[0] = d2;
        put_digest(2, 0, d2);
        run_sched(5);
        #1 srst_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        @(posedge clk); #1;
        srst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            chk64($sformatf("post-reset data_out c%0d", c), data_out, 64'd0);
            chk1($sformatf("post-reset SHA2_valid c%0d", c), SHA2_valid, 1'b0);
            chk1($sformatf("post-reset SHA3_valid c%0d", c), SHA3_valid, 1'b0);
            chk1($sformatf("post-reset busy c%0d", c), busy, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sha_dual_ctrl.md
# sha_dual_ctrl

Controller shared by the SHA-256 and SHA3-256 engines inside `top`. It launches both engines from one `enable` pulse and arbitrates the single read port of the 256x64b message SRAM between them. It also buffers each 256-bit digest and serialises it onto the 64-bit `data_out` bus with the `SHA2_valid` / `SHA3_valid` framing the system bench expects.

## Interface
Parameters:
- BW_SRAM_ADDR, 8, SRAM address width
- BW_SRAM_DATA, 64, SRAM word / output word width
- BW_DIGEST, 256, digest width (multiple of BW_SRAM_DATA; 4 words)

Ports:
- clk  in  1  system clock, rising edge
- srst_n  in  1  reset, asynchronous, active-low
- enable  in  1  start pulse for one message
- sha2_req / sha3_req  in  1  engine read request
- sha2_addr / sha3_addr  in  BW_SRAM_ADDR  engine read address
- sha2_gnt / sha3_gnt  out  1  request accepted this cycle
- sha2_rvalid / sha3_rvalid  out  1  `sram_data` belongs to this engine this cycle
- sram_addr  out  BW_SRAM_ADDR  SRAM read address
- sram_data  in  BW_SRAM_DATA  SRAM read data, 1-cycle latency
- sha2_start / sha3_start  out  1  engine start pulses
- sha2_done / sha3_done  in  1  digest-ready pulse
- sha2_digest / sha3_digest  in  BW_DIGEST  digest, valid with done
- SHA2_valid / SHA3_valid  out  1  first-word marker
- data_out  out  BW_SRAM_DATA  serialised digest word
- busy  out  1  message in flight
- err  out  1  sticky overflow flag

## Operation
- Start:
  - `enable` while `busy`=0 sets `busy`.
  - It pulses `sha2_start` and `sha3_start` for exactly 1 cycle, in the cycle after `enable`.
  - `enable` while `busy`=1 is ignored.
- Read arbitration:
  - Two-way round-robin. The pointer names the preferred requester and resets to SHA2.
  - Grant rules:
    - Only one requester asserts `req`: it is granted.
    - Both assert `req`: the preferred one is granted, and the pointer flips to the other.
  - `gnt` is combinational in the request cycle. `sram_addr` is the granted address, or 0 when no request is active.
  - The granted engine sees its `rvalid` high in the next cycle, with `sram_data` valid. The other engine's `rvalid` is low.
- Digest capture:
  - Each `done` pulse loads a 256-bit pending register and sets that engine's pending bit.
  - A `done` pulse while that engine's pending bit is set sets `err`. The new digest overwrites the old one.
- Output FSM, states IDLE, SEND2, SEND3, with a 2-bit word counter:
  - IDLE -> SEND2 if SHA2 is pending, else SEND3 if SHA3 is pending. SHA2 wins simultaneous pending.
  - In SEND*, `data_out` carries words [255:192], [191:128], [127:64], [63:0] over 4 consecutive cycles, MSW first.
  - `SHA*_valid` is high only in the cycle of word 0.
  - After word 3 the pending bit clears. The FSM goes to the other SEND state if that one is pending (back-to-back, no gap), else to IDLE.
- Completion: `busy` clears in the cycle after the second digest's word 3, i.e. both digests have been emitted.
- Reset:
  - Asserting `srst_n` at any time clears the FSM, the pending bits, the pointer, `busy` and `err`.
  - In-flight digests are discarded.

## Timing
- Reset values: all outputs 0.
- `enable` sampled at edge N -> `sha*_start` high N+1..N+2, `busy` high from N+1.
- Read round trip: `req` at cycle t -> `gnt`@t -> `rvalid` and data @t+1. Sustained throughput is 1 word/cycle for a single requester, alternating when both request.
- `done` sampled at edge N -> FSM leaves IDLE at N+1. `SHA*_valid` and word 0 are visible N+1..N+2. Word 3 is visible in cycle N+4.
- `done` arriving during the other engine's SEND: it is captured immediately and serialised directly after that engine's word 3.
- `data_out` is registered. It holds 0 in IDLE.

## Structure
- `sha_ctrl_pkg` holds:
  - the widths BW_SRAM_ADDR, BW_SRAM_DATA and BW_DIGEST;
  - `WORDS_PER_DIGEST`=4;
  - the output FSM state enum.
- Sub-module `sha_rr_arb2`: 2-requester round-robin arbiter with pointer and one-hot grant. The top level adds the rvalid tag register, start logic, pending registers and serialiser.

## Test plan
- Reset, then `enable` -> `sha2_start` and `sha3_start` 1-cycle pulses, `busy`=1. A second `enable` while busy produces no further starts.
- Both engines request every cycle (SHA2 addr 0x00.., SHA3 addr 0x80..) -> grants alternate SHA2, SHA3, SHA2…. `rvalid` follows one cycle later with matching `sram_data` from the preloaded SRAM.
- `sha2_done` with digest 0x0123…cdef -> `SHA2_valid` for one cycle with word 0x0123456789abcdef, then the remaining 3 words in order. `SHA3_valid` stays low.
- `sha2_done` and `sha3_done` in the same cycle -> SHA2 4 words, then SHA3 4 words back-to-back, `SHA3_valid` at cycle 5. `busy` drops after the last word.
- Second `sha3_done` before its first digest has been emitted -> `err`=1 and the latest SHA3 digest is emitted.
- `srst_n` low during word 2 of SEND2 -> all outputs 0 immediately. No further valids until a new `enable`.
